// File: rtl/layer_compositor_if.sv
// Register bus between the host/config master and the layer compositor.
interface layer_compositor_if;
    logic [4:0] regs_addr;
    logic [7:0] regs_wrdata;
    logic [7:0] regs_rddata;
    logic       regs_write;

    modport master (output regs_addr, output regs_wrdata, output regs_write, input regs_rddata);
    modport slave  (input regs_addr, input regs_wrdata, input regs_write, output regs_rddata);
endinterface

// File: rtl/layer_compositor.sv
// Merges NUM_LAYERS layer line buffers with a z-ordered sprite line buffer,
// applies an active window with border and a fractional upscaler, and clears sprites behind the reader.
module layer_compositor #(
    parameter int NUM_LAYERS = 2,
    parameter int ZW         = 2,
    parameter int LB_DEPTH   = 640,
    parameter int IDXW       = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    layer_compositor_if.slave       regs,
    input  logic [NUM_LAYERS-1:0]   layer_enabled,
    output logic [NUM_LAYERS-1:0]   layer_line_render_start,
    output logic [IDXW-1:0]         layer_lb_rdidx,
    input  logic [8*NUM_LAYERS-1:0] layer_lb_rddata,
    output logic [8:0]              line_idx,
    input  logic                    sprites_enabled,
    output logic                    sprites_line_render_start,
    output logic [IDXW-1:0]         sprites_lb_rdidx,
    input  logic [8+ZW-1:0]         sprites_lb_rddata,
    output logic [IDXW-1:0]         sprites_lb_wridx,
    output logic                    sprites_lb_wren,
    output logic [8+ZW-1:0]         sprites_lb_wrdata,
    input  logic [8:0]              display_line_idx,
    input  logic                    display_start_of_line,
    input  logic                    display_next_pixel,
    output logic [7:0]              display_data,
    output logic [1:0]              display_mode,
    output logic                    chroma_disable
);
    localparam logic [9:0] LB_MAX = 10'(LB_DEPTH - 1);

    logic [2:0]      ctrl0;
    logic [7:0]      hscale;
    logic [7:0]      border;
    logic [9:0]      hstart;
    logic [9:0]      hstop;

    logic [9:0]      dx;
    logic [16:0]     acc;
    logic [IDXW-1:0] rdidx;
    logic [IDXW-1:0] clr_ptr;
    logic            win_end;
    logic            final_done;
    logic            pix_d1, pix_d2;
    logic            act_d1, act_d2;

    logic            active;
    logic [7:0]      step;
    logic [9:0]      lbi;
    logic [7:0]      spr_col;
    logic [ZW-1:0]   spr_z;
    logic [7:0]      composed;

    assign line_idx          = display_line_idx;
    assign display_mode      = ctrl0[1:0];
    assign chroma_disable    = ctrl0[2];
    assign layer_lb_rdidx    = rdidx;
    assign sprites_lb_rdidx  = rdidx;
    assign sprites_lb_wrdata = '0;

    assign active  = (dx >= hstart) && (dx < hstop);
    assign step    = (hscale > 8'd128) ? 8'd128 : hscale;
    assign lbi     = acc[16:7];
    assign spr_col = sprites_lb_rddata[7:0];
    assign spr_z   = sprites_lb_rddata[8 +: ZW];

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl0  <= '0;
            hscale <= 8'd128;
            border <= '0;
            hstart <= '0;
            hstop  <= 10'd640;
        end else if (regs.regs_write) begin
            case (regs.regs_addr)
                5'd0: ctrl0       <= regs.regs_wrdata[2:0];
                5'd1: hscale      <= regs.regs_wrdata;
                5'd2: border      <= regs.regs_wrdata;
                5'd3: hstart[7:0] <= regs.regs_wrdata;
                5'd4: hstop[7:0]  <= regs.regs_wrdata;
                5'd5: begin
                    hstart[9:8] <= regs.regs_wrdata[1:0];
                    hstop[9:8]  <= regs.regs_wrdata[3:2];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        regs.regs_rddata = '0;
        case (regs.regs_addr)
            5'd0: regs.regs_rddata = {5'b0, ctrl0};
            5'd1: regs.regs_rddata = hscale;
            5'd2: regs.regs_rddata = border;
            5'd3: regs.regs_rddata = hstart[7:0];
            5'd4: regs.regs_rddata = hstop[7:0];
            5'd5: regs.regs_rddata = {4'b0, hstop[9:8], hstart[9:8]};
            default: regs.regs_rddata = '0;
        endcase
    end

    // Lower layers first; each later candidate overwrites, so the last non-zero wins.
    always_comb begin
        composed = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (sprites_enabled && spr_col != 8'd0 && spr_z == ZW'(k + 1))
                composed = spr_col;
            if (layer_enabled[k] && layer_lb_rddata[8*k +: 8] != 8'd0)
                composed = layer_lb_rddata[8*k +: 8];
        end
        if (sprites_enabled && spr_col != 8'd0 && spr_z == ZW'(NUM_LAYERS + 1))
            composed = spr_col;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            layer_line_render_start   <= '0;
            sprites_line_render_start <= 1'b0;
            dx           <= '0;
            acc          <= '0;
            rdidx        <= '0;
            win_end      <= 1'b0;
            final_done   <= 1'b0;
            clr_ptr      <= '0;
            pix_d1       <= 1'b0;
            pix_d2       <= 1'b0;
            act_d1       <= 1'b0;
            act_d2       <= 1'b0;
            display_data <= '0;
            sprites_lb_wren  <= 1'b0;
            sprites_lb_wridx <= '0;
        end else begin
            layer_line_render_start   <= {NUM_LAYERS{display_start_of_line}};
            sprites_line_render_start <= display_start_of_line;

            if (display_start_of_line) begin
                dx      <= '0;
                acc     <= '0;
                rdidx   <= '0;
                win_end <= 1'b0;
            end else if (display_next_pixel) begin
                if (dx != 10'h3FF)
                    dx <= dx + 10'd1;
                if (active)
                    acc <= acc + {9'd0, step};
                rdidx <= (lbi > LB_MAX) ? IDXW'(LB_MAX) : IDXW'(lbi);
                if (!active && dx >= hstart)
                    win_end <= 1'b1;
            end

            pix_d1 <= display_next_pixel && !display_start_of_line;
            act_d1 <= active;
            pix_d2 <= pix_d1;
            act_d2 <= act_d1;
            if (pix_d2)
                display_data <= act_d2 ? composed : border;

            // Entries strictly below the current read index have had their last read.
            sprites_lb_wren <= 1'b0;
            if (display_start_of_line) begin
                clr_ptr    <= '0;
                final_done <= 1'b0;
            end else if (clr_ptr < rdidx) begin
                sprites_lb_wren  <= 1'b1;
                sprites_lb_wridx <= clr_ptr;
                clr_ptr          <= clr_ptr + 1'b1;
            end else if (win_end && !final_done) begin
                sprites_lb_wren  <= 1'b1;
                sprites_lb_wridx <= clr_ptr;
                final_done       <= 1'b1;
            end
        end
    end
endmodule
